// File: rtl/wptr_full2.sv
// Write-domain pointer and full-flag stage of a style-2 async FIFO: Gray write
// pointer for the comparator, RAM address/enable, synchronised full, overflow and write count.
module wptr_full2 #(
    parameter int ADDRSIZE = 4,
    parameter int CNTW     = 16
) (
    input  logic                wclk,
    input  logic                dirclr_n,
    input  logic                winc,
    input  logic                afull_n,
    input  logic                ovf_clr,
    output logic [ADDRSIZE-1:0] wptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wen,
    output logic                wfull,
    output logic                overflow,
    output logic [CNTW-1:0]     wr_count,
    output logic [1:0]          full_state
);

    // State bits are {wfull, wfull2}; 2'b01 cannot be reached.
    typedef enum logic [1:0] {
        NOTFULL = 2'b00,
        DRAIN   = 2'b10,
        FULL    = 2'b11
    } full_t;

    full_t               state;
    logic                set_n;
    logic                accept;
    logic [ADDRSIZE-1:0] wbin;
    logic [ADDRSIZE-1:0] wbin_next;
    logic [ADDRSIZE-1:0] wgray_next;

    // Gating the set with dirclr_n makes a release while afull_n is low produce
    // a falling set edge, so the chain loads FULL right at release.
    assign set_n = afull_n | ~dirclr_n;

    always_ff @(posedge wclk or negedge dirclr_n or negedge set_n) begin
        if (!dirclr_n) begin
            state <= NOTFULL;
        end else if (!set_n) begin
            state <= FULL;
        end else begin
            // afull_n is known high here, so wfull2 always loads 0.
            case (state)
                FULL:    state <= DRAIN;
                DRAIN:   state <= NOTFULL;
                default: state <= NOTFULL;
            endcase
        end
    end

    assign wfull      = state[1];
    assign full_state = state;
    assign accept     = winc & ~wfull;
    assign wen        = accept;
    assign wbin_next  = wbin + ADDRSIZE'(1);
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    assign waddr      = wbin;

    always_ff @(posedge wclk or negedge dirclr_n) begin
        if (!dirclr_n) begin
            wbin     <= '0;
            wptr     <= '0;
            wr_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wbin     <= wbin_next;
                wptr     <= wgray_next;
                wr_count <= wr_count + CNTW'(1);
            end
            // Setting beats clearing when both happen on one edge.
            if (winc && wfull) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wptr_full2.sv
// Directed + random bench for wptr_full2 against a write-count / edge-count model.
module tb_wptr_full2;
    localparam int ADDRSIZE = 4;
    localparam int CNTW     = 6;

    logic                wclk = 1'b0;
    logic                dirclr_n;
    logic                winc;
    logic                afull_n;
    logic                ovf_clr;
    logic [ADDRSIZE-1:0] wptr;
    logic [ADDRSIZE-1:0] waddr;
    logic                wen;
    logic                wfull;
    logic                overflow;
    logic [CNTW-1:0]     wr_count;
    logic [1:0]          full_state;

    wptr_full2 #(.ADDRSIZE(ADDRSIZE), .CNTW(CNTW)) dut (
        .wclk       (wclk),
        .dirclr_n   (dirclr_n),
        .winc       (winc),
        .afull_n    (afull_n),
        .ovf_clr    (ovf_clr),
        .wptr       (wptr),
        .waddr      (waddr),
        .wen        (wen),
        .wfull      (wfull),
        .overflow   (overflow),
        .wr_count   (wr_count),
        .full_state (full_state)
    );

    always #5 wclk = ~wclk;

    // Model: total accepted writes, count of edges seen with afull_n high since
    // it was last low, and the sticky overflow.
    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_wr     = 0;
    int         m_rel    = 2;
    logic       m_full   = 1'b0;
    logic       m_ovf    = 1'b0;
    logic [3:0] gray_tab [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".waddr"},    32'(waddr),    32'(m_wr % 16));
        check({tag, ".wptr"},     32'(wptr),     32'(gray_tab[m_wr % 16]));
        check({tag, ".wr_count"}, 32'(wr_count), 32'(m_wr % (1 << CNTW)));
        check({tag, ".wfull"},    32'(wfull),    32'(m_full));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".wen"},      32'(wen),      32'(winc & ~m_full));
    endtask

    task automatic drive_afull(input logic v);
        if (!v && afull_n && dirclr_n) begin
            m_full = 1'b1;
            m_rel  = 0;
        end
        afull_n = v;
    endtask

    task automatic tick(input string tag);
        if (winc && m_full) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        if (winc && !m_full) m_wr++;
        if (!afull_n) m_rel = 0;
        else if (m_rel < 2) m_rel++;
        m_full = !afull_n || (m_rel < 2);
        @(posedge wclk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        dirclr_n = 1'b0;
        m_wr   = 0;
        m_ovf  = 1'b0;
        m_full = 1'b0;
        m_rel  = 2;
        #1;
        check_all({tag, ".in_reset"});
        dirclr_n = 1'b1;
        if (!afull_n) begin
            m_full = 1'b1;
            m_rel  = 0;
        end
        #1;
        check_all({tag, ".released"});
    endtask

    initial begin
        gray_tab = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                     4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
        dirclr_n = 1'b0;
        winc     = 1'b0;
        afull_n  = 1'b1;
        ovf_clr  = 1'b0;
        #2;
        check_all("reset");
        @(posedge wclk);
        #1;
        dirclr_n = 1'b1;
        #1;
        check_all("release");

        // Five writes, then on to a full pointer wrap.
        winc = 1'b1;
        for (int i = 0; i < 5; i++) tick("write5");
        for (int i = 5; i < 16; i++) tick("wrap");

        // Asynchronous full between edges, writes blocked, then two-edge release.
        drive_afull(1'b0);
        #1;
        check_all("async_full");
        for (int i = 0; i < 3; i++) tick("held_full");
        drive_afull(1'b1);
        tick("drain_edge1");
        tick("drain_edge2");
        winc = 1'b0;
        tick("idle");

        // Short glitch, then a second glitch during DRAIN restarting it.
        drive_afull(1'b0);
        #1;
        check_all("glitch1");
        #2;
        drive_afull(1'b1);
        tick("glitch1_e1");
        drive_afull(1'b0);
        #1;
        check_all("glitch2");
        #2;
        drive_afull(1'b1);
        tick("glitch2_e1");
        tick("glitch2_e2");

        // Overflow set and clear on one edge: set wins; then clear alone.
        drive_afull(1'b0);
        winc    = 1'b1;
        ovf_clr = 1'b1;
        tick("ovf_set_wins");
        winc = 1'b0;
        tick("ovf_clear");
        ovf_clr = 1'b0;
        drive_afull(1'b1);
        tick("ovf_rel1");
        tick("ovf_rel2");

        // Reset with afull_n low at wbin=7; full reasserts at release.
        do_reset("rst_a");
        winc = 1'b1;
        for (int i = 0; i < 7; i++) tick("to_seven");
        winc = 1'b0;
        drive_afull(1'b0);
        #1;
        check_all("pre_reset_full");
        do_reset("rst_full");
        drive_afull(1'b1);
        tick("post_rst1");
        tick("post_rst2");
        winc = 1'b1;
        tick("first_write");
        winc = 1'b0;

        // Random traffic with held and glitched full indications.
        for (int i = 0; i < 400; i++) begin
            int r;
            winc    = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                drive_afull(1'b0);
            end else if (r <= 3) begin
                drive_afull(1'b1);
            end else if (r == 4 && afull_n) begin
                drive_afull(1'b0);
                #1;
                check_all("rand_glitch");
                #2;
                drive_afull(1'b1);
            end
            #1;
            check_all("rand_pre");
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
